// File: rtl/fb_pkg.sv
// Shared types, active-area constants and RGB565 expansion for the dual frame buffer.
package fb_pkg;

    typedef logic [15:0] pixel_t;
    typedef logic [23:0] rgb_t;

    typedef enum logic [1:0] {
        WRITING,
        WAIT_SWAP,
        CLEARING
    } fb_state_t;

    localparam int ACTIVE_H = 1280;
    localparam int ACTIVE_V = 720;

    // Replicate the top bits so full-scale 5/6-bit values map to 8'hFF.
    function automatic rgb_t expand565(input pixel_t p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

endpackage

// File: rtl/fb_coord_scaler.sv
// Maps video hcount/vcount to a frame-buffer read address (registered) and
// delays active_draw by the same one cycle.
module fb_coord_scaler
    import fb_pkg::*;
#(
    parameter int FB_WIDTH = 320,
    parameter int H_SCALE  = 4,
    parameter int V_SCALE  = 3,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    input  logic              active_draw,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              active_d
);

    localparam int HS_W = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
    localparam int VS_W = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;

    logic [HS_W-1:0]   h_sub, hs_cur;
    logic [VS_W-1:0]   v_sub, vs_nxt;
    logic [ADDR_W-1:0] fb_x, x_cur;
    logic [ADDR_W-1:0] row_base, row_nxt;
    logic              line_start, step;

    // The line-start reset is applied combinationally so hcount==0 already
    // addresses column 0 of the (possibly advanced) row.
    always_comb begin
        line_start = (hcount == 11'd0);
        step       = active_draw && (hcount < 11'(ACTIVE_H));
        x_cur      = line_start ? '0 : fb_x;
        hs_cur     = line_start ? '0 : h_sub;
        vs_nxt     = v_sub;
        row_nxt    = row_base;
        if (line_start) begin
            if (vcount == 10'd0) begin
                vs_nxt  = '0;
                row_nxt = '0;
            end else if (vcount < 10'(ACTIVE_V)) begin
                if (v_sub == VS_W'(V_SCALE - 1)) begin
                    vs_nxt  = '0;
                    row_nxt = row_base + ADDR_W'(FB_WIDTH);
                end else begin
                    vs_nxt = v_sub + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_sub    <= '0;
            fb_x     <= '0;
            v_sub    <= '0;
            row_base <= '0;
            rd_addr  <= '0;
            active_d <= 1'b0;
        end else begin
            rd_addr  <= row_nxt + x_cur;
            active_d <= active_draw;
            v_sub    <= vs_nxt;
            row_base <= row_nxt;
            if (step && (hs_cur == HS_W'(H_SCALE - 1))) begin
                h_sub <= '0;
                fb_x  <= x_cur + 1'b1;
            end else if (step) begin
                h_sub <= hs_cur + 1'b1;
                fb_x  <= x_cur;
            end else begin
                h_sub <= hs_cur;
                fb_x  <= x_cur;
            end
        end
    end

endmodule

// File: rtl/dual_frame_buffer.sv
// Double-buffered frame store: writer fills the back buffer, video scans the front.
// Optional CLEAR_ON_SWAP_EN fills the new back buffer with CLEAR_COLOR after each swap.
//
// state     | meaning
// WRITING   | back buffer accepts ray-pipeline writes
// WAIT_SWAP | ray frame complete, waiting for the video frame boundary
// CLEARING  | (CLEAR_ON_SWAP_EN) filling back buffer with CLEAR_COLOR
module dual_frame_buffer
    import fb_pkg::*;
#(
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 240,
    parameter int H_SCALE   = 4,
    parameter int V_SCALE   = 3,
    parameter int PIXEL_W   = 16,
    parameter int ADDR_W    = $clog2(FB_WIDTH * FB_HEIGHT)
`ifdef CLEAR_ON_SWAP_EN
    ,
    parameter logic [PIXEL_W-1:0] CLEAR_COLOR = 16'h0000
`endif
) (
    input  logic               pixel_clk_in,
    input  logic               rst_in,
    input  logic [10:0]        hcount_in,
    input  logic [9:0]         vcount_in,
    input  logic               active_draw_in,
    input  logic               video_last_pixel_in,
    input  logic [ADDR_W-1:0]  address_in,
    input  logic [PIXEL_W-1:0] pixel_in,
    input  logic               pixel_valid_in,
    input  logic               ray_last_pixel_in,
    output logic               ready_out,
    output rgb_t               rgb_out,
    output logic               buffer_sel_out,
    output logic               frame_swapped_out,
    output logic               addr_err_out
);

    localparam int DEPTH = FB_WIDTH * FB_HEIGHT;

    fb_state_t          state;
    logic               accept, in_range, swap_now, wr_en;
    logic [ADDR_W-1:0]  wr_addr, rd_addr;
    logic [PIXEL_W-1:0] wr_data, rd0, rd1;
    logic               ad_d1, ad_d2, sel_d;

    logic [PIXEL_W-1:0] mem0 [DEPTH];
    logic [PIXEL_W-1:0] mem1 [DEPTH];

`ifdef CLEAR_ON_SWAP_EN
    logic [ADDR_W-1:0]  clr_cnt;
`endif

    always_comb begin
        accept   = pixel_valid_in && ready_out;
        in_range = {1'b0, address_in} < (ADDR_W + 1)'(DEPTH);
        swap_now = video_last_pixel_in &&
                   ((state == WAIT_SWAP) ||
                    ((state == WRITING) && accept && ray_last_pixel_in));
`ifdef CLEAR_ON_SWAP_EN
        if (state == CLEARING) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt;
            wr_data = CLEAR_COLOR;
        end else begin
            wr_en   = accept && in_range;
            wr_addr = address_in;
            wr_data = pixel_in;
        end
`else
        wr_en   = accept && in_range;
        wr_addr = address_in;
        wr_data = pixel_in;
`endif
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state             <= WRITING;
            ready_out         <= 1'b1;
            buffer_sel_out    <= 1'b0;
            frame_swapped_out <= 1'b0;
            addr_err_out      <= 1'b0;
`ifdef CLEAR_ON_SWAP_EN
            clr_cnt           <= '0;
`endif
        end else begin
            frame_swapped_out <= 1'b0;
            if (accept && !in_range)
                addr_err_out <= 1'b1;
            if (swap_now) begin
                buffer_sel_out    <= ~buffer_sel_out;
                frame_swapped_out <= 1'b1;
`ifdef CLEAR_ON_SWAP_EN
                state             <= CLEARING;
                ready_out         <= 1'b0;
`else
                state             <= WRITING;
                ready_out         <= 1'b1;
`endif
            end else begin
                case (state)
                    WRITING: begin
                        if (accept && ray_last_pixel_in) begin
                            state     <= WAIT_SWAP;
                            ready_out <= 1'b0;
                        end
                    end
                    WAIT_SWAP: ready_out <= 1'b0;
`ifdef CLEAR_ON_SWAP_EN
                    CLEARING: begin
                        if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                            clr_cnt   <= '0;
                            state     <= WRITING;
                            ready_out <= 1'b1;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
`endif
                    default: begin
                        state     <= WRITING;
                        ready_out <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Back buffer is ~buffer_sel_out: sel=1 writes bank 0, sel=0 writes bank 1.
    always_ff @(posedge pixel_clk_in) begin
        if (wr_en && buffer_sel_out)
            mem0[wr_addr] <= wr_data;
        rd0 <= mem0[rd_addr];
    end

    always_ff @(posedge pixel_clk_in) begin
        if (wr_en && !buffer_sel_out)
            mem1[wr_addr] <= wr_data;
        rd1 <= mem1[rd_addr];
    end

    fb_coord_scaler #(
        .FB_WIDTH (FB_WIDTH),
        .H_SCALE  (H_SCALE),
        .V_SCALE  (V_SCALE),
        .ADDR_W   (ADDR_W)
    ) u_scaler (
        .clk         (pixel_clk_in),
        .rst         (rst_in),
        .hcount      (hcount_in),
        .vcount      (vcount_in),
        .active_draw (active_draw_in),
        .rd_addr     (rd_addr),
        .active_d    (ad_d1)
    );

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            sel_d   <= 1'b0;
            ad_d2   <= 1'b0;
            rgb_out <= '0;
        end else begin
            sel_d   <= buffer_sel_out;
            ad_d2   <= ad_d1;
            rgb_out <= ad_d2 ? expand565(sel_d ? rd1 : rd0) : '0;
        end
    end

endmodule

// File: doc/dual_frame_buffer.md
Name: dual_frame_buffer

Overview:
Double-buffered, parametrised frame store between the transformation stage and the HDMI TMDS encoders. The ray pipeline writes one complete low-resolution frame into the back buffer while the video path scans the front buffer, upscaled to the 1280x720 active area. Buffers swap only at the video frame boundary, so the display never tears. Back-pressure to the writer replaces the old single-buffer, fire-and-forget write.

Parameters:
- FB_WIDTH, 320, frame-buffer columns.
- FB_HEIGHT, 240, frame-buffer rows.
- H_SCALE, 4, screen pixels per fb column (FB_WIDTH*H_SCALE = 1280).
- V_SCALE, 3, screen lines per fb row (FB_HEIGHT*V_SCALE = 720).
- PIXEL_W, 16, stored pixel width (RGB565).
- ADDR_W, $clog2(FB_WIDTH*FB_HEIGHT), write/read address width (17).
- CLEAR_COLOR, 16'h0000, fill value; used only with CLEAR_ON_SWAP_EN.

Ports:
- pixel_clk_in  in  1  pixel clock, 74.25 MHz.
- rst_in  in  1  asynchronous, active-high reset.
- hcount_in  in  11  video horizontal count.
- vcount_in  in  10  video vertical count.
- active_draw_in  in  1  video active region.
- video_last_pixel_in  in  1  one-cycle pulse on the last pixel of the video frame.
- address_in  in  ADDR_W  write address, y*FB_WIDTH + x.
- pixel_in  in  PIXEL_W  write data.
- pixel_valid_in  in  1  write request.
- ray_last_pixel_in  in  1  qualifies the final write of a ray frame; sampled only when pixel_valid_in && ready_out.
- ready_out  out  1  back buffer accepts writes.
- rgb_out  out  24  expanded RGB888 for the TMDS encoders.
- buffer_sel_out  out  1  index of the front buffer.
- frame_swapped_out  out  1  one-cycle pulse when the swap takes effect.
- addr_err_out  out  1  sticky; set when a write is dropped for address_in >= FB_WIDTH*FB_HEIGHT.

Behaviour:
- Reset (async assert, sync release): rgb_out=0, buffer_sel_out=0 (front=0, back=1), ready_out=1, frame_swapped_out=0, addr_err_out=0, state WRITING, scaler counters 0.
- Write handshake: a write occurs on a cycle with pixel_valid_in && ready_out. If ready_out=0, the writer holds its data and nothing is written. Out-of-range addresses are dropped and set addr_err_out. ray_last_pixel_in on an out-of-range beat still ends the frame.
- FSM WRITING: accepted beat with ray_last_pixel_in -> WAIT_SWAP; that final pixel is written.
- FSM WAIT_SWAP: ready_out=0. On video_last_pixel_in, toggle buffer_sel_out, pulse frame_swapped_out next cycle, then return to WRITING (or CLEARING, see the optional feature).
- If the accepted last beat and video_last_pixel_in coincide, the last pixel is written and the swap occurs in that same cycle. frame_swapped_out pulses the next cycle.
- A video_last_pixel_in while in WRITING has no effect; the front buffer is shown again.
- Read path (fb_coord_scaler):
  - The h sub-counter steps 0..H_SCALE-1 during active_draw_in; fb_x advances on its wrap.
  - fb_x and the sub-counter reset when hcount_in==0.
  - The v sub-counter and fb_y advance on hcount_in==0 with vcount_in < 720, and reset at vcount_in==0.
  - row_base accumulates FB_WIDTH per fb_y step; no multiplier.
- Read latency: fixed 3 cycles from hcount_in/vcount_in to rgb_out (address register, BRAM read, expansion register). The top level delays hs/vs/ad by 3 to match.
- Expansion: R={p[15:11],p[15:13]}, G={p[10:5],p[10:9]}, B={p[4:0],p[4:2]}.
- rgb_out=0 when the delayed active_draw is low.
- Memory: two simple dual-port BRAMs of FB_WIDTH*FB_HEIGHT x PIXEL_W. Writes go to back = ~buffer_sel_out; reads come from front.
- Reset mid-frame: the current ray frame is abandoned; memory contents are not cleared.

Optional Feature:
CLEAR_ON_SWAP_EN:
- When defined, after each swap the FSM enters CLEARING.
- An internal counter writes CLEAR_COLOR to back-buffer addresses 0..FB_WIDTH*FB_HEIGHT-1, one per cycle, with ready_out=0 throughout.
- On the last address it returns to WRITING (76800 cycles, which is less than one 1650x750 frame).
- Without the macro there is no CLEARING state, and the back buffer keeps stale content from two frames earlier.

Decomposition:
- Package fb_pkg: pixel_t (16-bit RGB565), rgb_t (24-bit), the fb_state_t enum {WRITING, WAIT_SWAP, CLEARING}, the ACTIVE_H=1280 and ACTIVE_V=720 constants, and the function expand565.
- Sub-module fb_coord_scaler: counters plus row_base accumulation that produce the read address and the delayed active signal. The top module holds the FSM, write muxing and the two BRAMs.

Test Plan:
- Write 0xF800 at address 0 with the last flag, then pulse video_last_pixel_in -> frame_swapped_out pulses; at hcount=0..3, vcount=0, rgb_out=24'hFF0000 3 cycles later; at hcount=4, the value stored at address 1.
- With last written and in WAIT_SWAP, hold pixel_valid_in=1 -> ready_out=0 and no writes until video_last_pixel_in; the write is accepted in the cycle after the swap.
- Accepted last beat coincides with video_last_pixel_in -> swap that cycle; buffer_sel_out goes 0->1; the new front contains the last pixel.
- Write at address 76800 -> dropped, addr_err_out=1 and stays 1; back-buffer data unchanged.
- Assert rst_in in WAIT_SWAP -> all outputs at reset values immediately; ready_out=1 after release.
- With CLEAR_ON_SWAP_EN, after a swap -> ready_out low for exactly 76800 cycles; the old front then reads 24'h000000 after the next swap.
